// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared types, flag constants and NZP helper for the writeback register file
package writeback_regfile_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC   = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  localparam int MAX_W = 64;

  // Callers zero-extend their data and name the sign bit; zero-extension keeps the zero test valid.
  function automatic logic [2:0] nzp(input logic [MAX_W-1:0] data, input logic [5:0] msb);
    if (data[msb]) return PSR_N;
    else if (data == '0) return PSR_Z;
    else return PSR_P;
  endfunction

endpackage

// File: rtl/wb_regfile_core.sv
// rtl/wb_regfile_core.sv - register storage with one synchronous write port and two asynchronous read ports
module wb_regfile_core #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr1_i,
  input  logic [ADDR_W-1:0]     raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && ({1'b0, waddr_i} < NUM_REGS_L)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Indices past the last register read as zero rather than aliasing.
  assign rdata1_o = ({1'b0, raddr1_i} < NUM_REGS_L) ? mem_q[raddr1_i] : '0;
  assign rdata2_o = ({1'b0, raddr2_i} < NUM_REGS_L) ? mem_q[raddr2_i] : '0;

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage: source mux, NZP flags, read bypass and commit pulse
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         NUM_REGS   = 8,
  parameter int         BYPASS     = 1,
  parameter logic [2:0] PSR_RESET  = 3'b010,
  localparam int        ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_writeback,
  input  logic [1:0]            W_Control,
  input  logic [DATA_WIDTH-1:0] aluout,
  input  logic [DATA_WIDTH-1:0] memout,
  input  logic [DATA_WIDTH-1:0] pcout,
  input  logic [ADDR_W-1:0]     dr,
  input  logic [ADDR_W-1:0]     sr1,
  input  logic [ADDR_W-1:0]     sr2,
  output logic [DATA_WIDTH-1:0] VSR1,
  output logic [DATA_WIDTH-1:0] VSR2,
  output logic [2:0]            psr,
  output logic                  writeback_enb_out
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
  localparam bit              BYP        = (BYPASS != 0);

  wb_sel_e               sel;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_qual;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [2:0]            psr_d, psr_q;
  logic                  pulse_q;

  assign sel = wb_sel_e'(W_Control);

  always_comb begin
    din = '0;
    case (sel)
      WB_ALU:  din = aluout;
      WB_MEM:  din = memout;
      WB_PC:   din = pcout;
      default: din = '0;
    endcase
  end

  // Folding reset in here drops a colliding write and suppresses bypass during reset.
  assign wr_qual = enable_writeback && (sel != WB_NONE) &&
                   ({1'b0, dr} < NUM_REGS_L) && !reset;

  wb_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W)
  ) u_core (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (wr_qual),
    .waddr_i  (dr),
    .wdata_i  (din),
    .raddr1_i (sr1),
    .raddr2_i (sr2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  always_comb begin
    psr_d = psr_q;
    if (wr_qual) psr_d = nzp(MAX_W'(din), 6'(DATA_WIDTH-1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      psr_q   <= PSR_RESET;
      pulse_q <= 1'b0;
    end else begin
      psr_q   <= psr_d;
      pulse_q <= wr_qual;
    end
  end

  assign VSR1 = (BYP && wr_qual && (dr == sr1)) ? din : rd1;
  assign VSR2 = (BYP && wr_qual && (dr == sr2)) ? din : rd2;

  assign psr               = psr_q;
  assign writeback_enb_out = pulse_q;

endmodule
